// File: rtl/dual_stream_source.sv
// Dual-lane test stream source. Each lane walks an arithmetic sequence of
// 32-bit words from its seed, inserts a one-cycle flush bubble every
// FLUSH_PERIOD accepted items, and parks in DONE after NUM_ITEMS items.
// A registered, sticky done flag rises once both lanes have finished.

module dual_stream_lane #(
    parameter int          NUM_ITEMS    = 16,
    parameter int          FLUSH_PERIOD = 8,
    parameter logic [31:0] SEED         = 32'h0000_0001,
    parameter logic [31:0] STEP         = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] data,
    output logic        valid,
    output logic        flush,
    output logic        finished
);

    localparam logic [15:0] NUM_ITEMS_C    = 16'(NUM_ITEMS);
    localparam logic [15:0] FLUSH_PERIOD_C = 16'(FLUSH_PERIOD);
    localparam bit          FLUSH_ENABLED  = (FLUSH_PERIOD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] data_next;
    logic [15:0] issued, issued_next;
    logic [15:0] period, period_next;

    // Data advance wraps modulo 2^32 by construction of the 32-bit sum.
    function automatic logic [31:0] next_word(input logic [31:0] word);
        return word + STEP;
    endfunction

    // State, data word and counters; reset restarts the stream from the seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            data   <= SEED;
            issued <= 16'd0;
            period <= 16'd0;
        end else begin
            state  <= state_next;
            data   <= data_next;
            issued <= issued_next;
            period <= period_next;
        end
    end

    // Next-state logic: advance only on an unstalled SEND cycle; completion
    // takes priority over a flush that falls due on the same item.
    always_comb begin
        state_next  = state;
        data_next   = data;
        issued_next = issued;
        period_next = period;
        case (state)
            IDLE: state_next = SEND;
            SEND: begin
                if (!stall) begin
                    data_next   = next_word(data);
                    issued_next = issued + 16'd1;
                    if (issued_next == NUM_ITEMS_C) begin
                        state_next  = DONE;
                        period_next = period + 16'd1;
                    end else if (FLUSH_ENABLED && (period + 16'd1 == FLUSH_PERIOD_C)) begin
                        state_next  = FLUSH;
                        period_next = 16'd0;
                    end else begin
                        period_next = period + 16'd1;
                    end
                end
            end
            FLUSH:   state_next = SEND;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    assign valid    = (state == SEND);
    assign flush    = (state == FLUSH);
    assign finished = (state == DONE);

endmodule

module dual_stream_source #(
    parameter int          NUM_ITEMS    = 16,
    parameter int          FLUSH_PERIOD = 8,
    parameter logic [31:0] SEED_1       = 32'h0000_0001,
    parameter logic [31:0] SEED_2       = 32'h0000_1000,
    parameter logic [31:0] STEP         = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_1,
    input  logic        stall_2,
    output logic [31:0] pipeline1_inputs,
    output logic [31:0] pipeline2_inputs,
    output logic [1:0]  in_valid,
    output logic        flush_1,
    output logic        flush_2,
    output logic        done
);

    logic valid_1, valid_2;
    logic finished_1, finished_2;

    dual_stream_lane #(
        .NUM_ITEMS    (NUM_ITEMS),
        .FLUSH_PERIOD (FLUSH_PERIOD),
        .SEED         (SEED_1),
        .STEP         (STEP)
    ) lane_1 (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall_1),
        .data     (pipeline1_inputs),
        .valid    (valid_1),
        .flush    (flush_1),
        .finished (finished_1)
    );

    dual_stream_lane #(
        .NUM_ITEMS    (NUM_ITEMS),
        .FLUSH_PERIOD (FLUSH_PERIOD),
        .SEED         (SEED_2),
        .STEP         (STEP)
    ) lane_2 (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall_2),
        .data     (pipeline2_inputs),
        .valid    (valid_2),
        .flush    (flush_2),
        .finished (finished_2)
    );

    assign in_valid = {valid_2, valid_1};

    // Sticky completion flag, one cycle behind the later lane reaching DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= done | (finished_1 & finished_2);
        end
    end

endmodule

// File: tb/tb_dual_stream_source.sv
// Scoreboard bench for dual_stream_source: stimulus pushes expected items and
// flush pulses per lane; a negedge monitor compares presented outputs.

module tb_dual_stream_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic rst_b = 1'b0;
    logic stall_1 = 1'b0;
    logic stall_2 = 1'b0;

    logic [31:0] d0_p1, d0_p2, d1_p1, d1_p2, d2_p1, d2_p2;
    logic [1:0]  d0_v, d1_v, d2_v;
    logic        d0_f1, d0_f2, d1_f1, d1_f2, d2_f1, d2_f2;
    logic        d0_done, d1_done, d2_done;

    dual_stream_source dut0 (
        .clk(clk), .reset(reset), .stall_1(stall_1), .stall_2(stall_2),
        .pipeline1_inputs(d0_p1), .pipeline2_inputs(d0_p2), .in_valid(d0_v),
        .flush_1(d0_f1), .flush_2(d0_f2), .done(d0_done)
    );

    dual_stream_source #(
        .NUM_ITEMS(4), .FLUSH_PERIOD(0), .SEED_1(32'hFFFF_FFFE)
    ) dut1 (
        .clk(clk), .reset(rst_b), .stall_1(1'b0), .stall_2(1'b0),
        .pipeline1_inputs(d1_p1), .pipeline2_inputs(d1_p2), .in_valid(d1_v),
        .flush_1(d1_f1), .flush_2(d1_f2), .done(d1_done)
    );

    dual_stream_source #(
        .NUM_ITEMS(8), .FLUSH_PERIOD(8)
    ) dut2 (
        .clk(clk), .reset(rst_b), .stall_1(1'b0), .stall_2(1'b0),
        .pipeline1_inputs(d2_p1), .pipeline2_inputs(d2_p2), .in_valid(d2_v),
        .flush_1(d2_f1), .flush_2(d2_f2), .done(d2_done)
    );

    typedef struct {
        bit          is_flush;
        logic [31:0] data;
        int          first;
        int          last;
    } exp_t;

    exp_t q [6][$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_exp [3];
    bit   done_seen [3];

    // Cycle number since the last release of dut0's reset.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) fail(name, got, exp);
    endtask

    task automatic mon_lane(input int id, input logic v, input logic f, input logic [31:0] d);
        exp_t e;
        if (q[id].size() == 0 || cyc < q[id][0].first) begin
            if (v || f) begin
                checks++;
                fail($sformatf("lane%0d_unexpected", id), {30'd0, f, v}, 32'd0);
            end
        end else begin
            e = q[id][0];
            check($sformatf("lane%0d_ctl", id), {30'd0, f, v}, e.is_flush ? 32'd2 : 32'd1);
            check($sformatf("lane%0d_data", id), d, e.data);
            if (cyc >= e.last) void'(q[id].pop_front());
        end
    endtask

    task automatic mon_done(input int id, input logic dn, input logic r);
        if (r) begin
            done_seen[id] = 1'b0;
        end else if (dn && !done_seen[id]) begin
            done_seen[id] = 1'b1;
            check($sformatf("done%0d_cycle", id), cyc, done_exp[id]);
        end
    endtask

    // Monitor: compares whatever each lane presents against its queue front.
    always @(negedge clk) begin
        if (!reset && cyc > 0) begin
            mon_lane(0, d0_v[0], d0_f1, d0_p1);
            mon_lane(1, d0_v[1], d0_f2, d0_p2);
        end
        if (!rst_b && cyc > 0) begin
            mon_lane(2, d1_v[0], d1_f1, d1_p1);
            mon_lane(3, d1_v[1], d1_f2, d1_p2);
            mon_lane(4, d2_v[0], d2_f1, d2_p1);
            mon_lane(5, d2_v[1], d2_f2, d2_p2);
        end
        mon_done(0, d0_done, reset);
        mon_done(1, d1_done, rst_b);
        mon_done(2, d2_done, rst_b);
    end

    // Expected stream of one lane with STEP = 1; item hold_item is held for
    // hold extra stalled cycles.
    task automatic push_lane(input int id, input logic [31:0] seed, input int n,
                             input int period, input int hold_item, input int hold);
        int          c = 1;
        logic [31:0] d = seed;
        exp_t        e;
        for (int i = 1; i <= n; i++) begin
            e.is_flush = 1'b0;
            e.data     = d;
            e.first    = c;
            e.last     = c + ((i == hold_item) ? hold : 0);
            q[id].push_back(e);
            c = e.last + 1;
            d = d + 32'd1;
            if (i != n && period != 0 && (i % period) == 0) begin
                e.is_flush = 1'b1;
                e.data     = d;
                e.first    = c;
                e.last     = c;
                q[id].push_back(e);
                c++;
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc < n) begin
            checks++;
            fail("wait_timeout", cyc, n);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_valid"}, {30'd0, d0_v}, 32'd0);
        check({tag, "_flush"}, {30'd0, d0_f2, d0_f1}, 32'd0);
        check({tag, "_done"}, {31'd0, d0_done}, 32'd0);
        check({tag, "_p1"}, d0_p1, 32'h0000_0001);
        check({tag, "_p2"}, d0_p2, 32'h0000_1000);
    endtask

    task automatic assert_reset(input string tag);
        reset = 1'b1;
        #1;
        check_reset(tag);
        q[0].delete();
        q[1].delete();
        stall_1 = 1'b0;
        stall_2 = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_q1_empty"}, q[0].size(), 32'd0);
        check({tag, "_q2_empty"}, q[1].size(), 32'd0);
        check({tag, "_done_seen"}, {31'd0, done_seen[0]}, 32'd1);
        check({tag, "_done_held"}, {31'd0, d0_done}, 32'd1);
        check({tag, "_final_p1"}, d0_p1, 32'h0000_0011);
        check({tag, "_final_p2"}, d0_p2, 32'h0000_1010);
        check({tag, "_final_valid"}, {30'd0, d0_v}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Defaults, wraparound config and NUM_ITEMS == FLUSH_PERIOD config.
        #1;
        reset = 1'b1;
        rst_b = 1'b1;
        #1;
        check_reset("init");
        check("init_dut1_p1", d1_p1, 32'hFFFF_FFFE);
        check("init_dut2_v", {30'd0, d2_v}, 32'd0);
        push_lane(0, 32'h0000_0001, 16, 8, 0, 0);
        push_lane(1, 32'h0000_1000, 16, 8, 0, 0);
        push_lane(2, 32'hFFFF_FFFE, 4, 0, 0, 0);
        push_lane(3, 32'h0000_1000, 4, 0, 0, 0);
        push_lane(4, 32'h0000_0001, 8, 8, 0, 0);
        push_lane(5, 32'h0000_1000, 8, 8, 0, 0);
        done_exp[0] = 19;
        done_exp[1] = 6;
        done_exp[2] = 10;
        @(negedge clk);
        #2;
        reset = 1'b0;
        rst_b = 1'b0;
        wait_cyc(20);
        stall_1 = 1'b1;
        wait_cyc(23);
        stall_1 = 1'b0;
        end_checks("dflt");
        for (int i = 2; i < 6; i++) check($sformatf("q%0d_empty", i), q[i].size(), 32'd0);
        check("dut1_done_seen", {31'd0, done_seen[1]}, 32'd1);
        check("dut2_done_seen", {31'd0, done_seen[2]}, 32'd1);
        check("dut1_final_p1", d1_p1, 32'h0000_0002);
        check("dut2_final_p1", d2_p1, 32'h0000_0009);

        // Async reset while lane 1 is stalled on word 6.
        @(negedge clk);
        #2;
        assert_reset("pre_mid");
        push_lane(0, 32'h0000_0001, 16, 8, 6, 1000);
        push_lane(1, 32'h0000_1000, 16, 8, 0, 0);
        done_exp[0] = 1000;
        release_reset();
        wait_cyc(6);
        stall_1 = 1'b1;
        wait_cyc(7);
        #2;
        assert_reset("async_mid");

        // Restart from seed; stall lane 1 for three cycles on word 5.
        push_lane(0, 32'h0000_0001, 16, 8, 5, 3);
        push_lane(1, 32'h0000_1000, 16, 8, 0, 0);
        done_exp[0] = 22;
        release_reset();
        wait_cyc(5);
        stall_1 = 1'b1;
        wait_cyc(8);
        stall_1 = 1'b0;
        wait_cyc(25);
        end_checks("stall5");

        // Stall held across the flush cycle.
        @(negedge clk);
        #2;
        assert_reset("pre_flush_stall");
        push_lane(0, 32'h0000_0001, 16, 8, 9, 3);
        push_lane(1, 32'h0000_1000, 16, 8, 0, 0);
        done_exp[0] = 22;
        release_reset();
        wait_cyc(9);
        stall_1 = 1'b1;
        wait_cyc(13);
        stall_1 = 1'b0;
        wait_cyc(25);
        end_checks("flush_stall");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_stream_source.md
DUAL_STREAM_SOURCE -- requirements
Module: dual_stream_source

Interface
REQ-001 Parameter NUM_ITEMS, default 16: items issued per lane before completion; legal range 1..65535.
REQ-002 Parameter FLUSH_PERIOD, default 8: accepted items per lane between flush pulses; 0 disables flushing.
REQ-003 Parameter SEED_1, default 32'h0000_0001: first data word on lane 1.
REQ-004 Parameter SEED_2, default 32'h0000_1000: first data word on lane 2.
REQ-005 Parameter STEP, default 32'h0000_0001: per-item data increment, both lanes.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 stall_1  input  1  downstream global stall for lane 1; 1 = current item not accepted.
REQ-009 stall_2  input  1  downstream global stall for lane 2.
REQ-010 pipeline1_inputs  output  32  lane 1 data word.
REQ-011 pipeline2_inputs  output  32  lane 2 data word.
REQ-012 in_valid  output  2  bit 0 = lane 1 valid, bit 1 = lane 2 valid.
REQ-013 flush_1  output  1  one-cycle lane 1 flush pulse.
REQ-014 flush_2  output  1  one-cycle lane 2 flush pulse.
REQ-015 done  output  1  high once both lanes have finished; sticky until reset.

Function
REQ-016 Lanes SHALL be independent, identical FSMs (lane 1 uses stall_1/flush_1/in_valid[0]/SEED_1; lane 2 uses stall_2/flush_2/in_valid[1]/SEED_2) with states IDLE, SEND, FLUSH, DONE.
REQ-017 IDLE: outputs at reset values; SHALL move to SEND on the first rising edge after reset deasserts.
REQ-018 SEND: in_valid bit = 1, data = current lane word; item accepted on a rising edge where the lane's stall = 0.
REQ-019 While the lane's stall = 1 in SEND, data and in_valid SHALL hold stable, with no counter advance.
REQ-020 On acceptance: data += STEP (modulo 2^32, wrap 32'hFFFF_FFFF + 1 = 0); issued count += 1; period count += 1.
REQ-021 After acceptance, if issued count == NUM_ITEMS, next state SHALL be DONE, with no flush even if the period is also reached.
REQ-022 Otherwise, if FLUSH_PERIOD != 0 and period count == FLUSH_PERIOD, next state SHALL be FLUSH and period count clears to 0; else remain in SEND.
REQ-023 FLUSH: lane flush = 1 and in_valid bit = 0 for exactly one cycle, independent of stall; data unchanged; next state SEND.
REQ-024 DONE: in_valid bit = 0, flush = 0, data holds the last value + STEP; stall ignored; no exit except reset.
REQ-025 done SHALL be registered: 1 in the cycle after the later lane enters DONE, and held until reset.
REQ-026 Throughput: unstalled, one item per cycle per lane; the flush bubble costs exactly one cycle.
REQ-027 Counters: issued count 16 bits, period count 16 bits; no other arithmetic.

Reset
REQ-028 Asserting reset at any time, including mid-stall or during FLUSH, SHALL immediately force: in_valid = 2'b00, flush_1 = flush_2 = 0, done = 0, pipeline1_inputs = SEED_1, pipeline2_inputs = SEED_2, both FSMs to IDLE, all counters to 0.
REQ-029 After reset release, streams SHALL restart from the seeds with no carried-over state.

Verification
REQ-030 Defaults, no stall: lane 1 issues 1..8 on cycles 1-8, flush_1 on cycle 9, 9..16 on cycles 10-17, DONE from cycle 18, done = 1 on cycle 19; lane 2 identical timing, starting at 32'h1000.
REQ-031 stall_1 = 1 for 3 cycles while lane 1 presents 5 -> word 5 and in_valid[0] held for 4 cycles total; lane 2 unaffected and finishes 3 cycles earlier; done follows lane 1.
REQ-032 stall_1 = 1 continuously across the FLUSH cycle -> flush_1 pulses once for 1 cycle; lane 1 then holds word 9 valid until the stall clears.
REQ-033 SEED_1 = 32'hFFFF_FFFE, STEP = 1, NUM_ITEMS = 4, FLUSH_PERIOD = 0 -> lane 1 data FFFF_FFFE, FFFF_FFFF, 0, 1; no flush pulses.
REQ-034 NUM_ITEMS = 8, FLUSH_PERIOD = 8 -> 8 items, no flush pulse, lane enters DONE directly.
REQ-035 reset asserted asynchronously mid-stream (lane 1 at word 6, stalled) -> outputs take reset values before the next clock edge; after release lane 1 restarts at 1.
